gpio_irq: RTL
=============

# gpio_irq

Parametrised Wishbone GPIO slave: the next generation of the fixed 8-pin `gpio` peripheral. It adds per-pin direction control, a configurable-depth input synchroniser and per-pin edge-triggered interrupts with sticky, write-1-to-clear pending bits. It sits on the shared CPU Wishbone bus alongside flash, SPRAM and `mtimer`, and its `interrupt` output feeds the CPU external interrupt input.

## Interface
- `BASE_ADDRESS`, default `'h4000_0000`: byte base of the 32-byte register window; must be 32-byte aligned.
- `WIDTH`, default 8: number of pins, 1..32.
- `SYNC_STAGES`, default 2: input synchroniser depth, ≥2.
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk_i`  in  1: clock.
- `rst_i`  in  1: synchronous active-high reset.
- `stb_i`, `cyc_i`  in  1: Wishbone strobe and cycle.
- `adr_i`  in  32: byte address.
- `sel_i`  in  4: byte lane selects.
- `dat_i`  in  32: write data.
- `dat_o`  out  32: read data.
- `we_i`  in  1: write enable.
- `ack_o`  out  1: acknowledge.
- `err_o`, `rty_o`  out  1: tied 0.
- `pin_input`  in  WIDTH: asynchronous pin levels.
- `pin_output`  out  WIDTH: output levels.
- `pin_oe`  out  WIDTH: output enables (1 = drive).
- `interrupt`  out  1: level interrupt.

## Operation
- Hit: `stb_i & cyc_i & (adr_i[31:5] == BASE_ADDRESS[31:5])`. Register index is `adr_i[4:2]`; `adr_i[1:0]` is ignored.
- Register map (offsets), with bits ≥ WIDTH reading 0 and ignoring writes:
  - 0x00 IN (RO): synchroniser output `s`.
  - 0x04 OUT (RW): drives `pin_output`.
  - 0x08 DIR (RW): drives `pin_oe`.
  - 0x0C IEN (RW): interrupt enable per pin.
  - 0x10 POL (RW): 1 = rising edge, 0 = falling edge.
  - 0x14 PEND (R/W1C): pending interrupts.
  - 0x18 BOTH: see Configuration.
  - 0x1C: reserved; reads 0, writes are ignored, and the access is still acked.
- Writes honour `sel_i` per byte lane, including W1C on PEND.
- Edge detect:
  - `p` is `s` delayed by one cycle.
  - `rise = s & ~p`, `fall = ~s & p`.
  - `edge = IEN & (POL ? rise : fall)` per pin.
- Pending update: `PEND <= (PEND & ~w1c) | edge`. If a set and a clear hit the same bit in the same cycle, the set wins.
- Clearing IEN does not clear PEND. PEND bits only set while IEN = 1.
- `interrupt = |(PEND & IEN)`, driven combinationally from registers only.
- `dat_o` is 0 whenever `ack_o` = 0, so it can be OR-combined on the shared bus.
- Reset values: OUT, DIR, IEN, POL, PEND, BOTH, sync chain, `p`, `ack_o` and `dat_o` are all 0. Consequently `pin_output`, `pin_oe` and `interrupt` are 0.

## Timing
- Bus handshake:
  - `ack_o <= hit & ~ack_o`: a one-cycle pulse on the edge after the request is sampled.
  - `dat_o` is registered and valid in the same cycle as `ack_o`.
  - Holding `stb_i` high yields acks on alternate cycles; each ack is one complete transaction.
- Writes commit on the same edge that raises `ack_o`. OUT, DIR and IEN changes are visible on the outputs in the ack cycle.
- Input latency:
  - A pin change sampled at edge N appears in IN after edge N+SYNC_STAGES-1.
  - The corresponding PEND bit and `interrupt` rise one edge later.
- A read of PEND in the same cycle as an edge set returns the pre-set value; the new bit is visible on the next read.
- Reset mid-transaction: `ack_o` is 0 on the cycle after reset asserts and no write commits. The master must restart the transaction.
- `rst_i` has priority over all register updates.

## Configuration
- Macro: `GPIO_IRQ_BOTH_EDGE_EN`.
- Defined:
  - Register 0x18 BOTH (RW) exists.
  - Where BOTH = 1, `edge = IEN & (rise | fall)` and POL is ignored for that pin.
- Undefined:
  - 0x18 behaves as reserved: reads 0, writes are ignored, ack is still given.
  - Only POL-selected single-edge detection is available.

## Test plan
- Reset, then read every offset: all reads return 0, each ack lasts exactly one cycle, and `pin_oe` = 0.
- Write OUT = 0xA5 with `sel_i` = 4'b0001, then DIR = 0xFF: `pin_output` = 8'hA5 and `pin_oe` = 8'hFF in the ack cycle. A write of 0x1234_56FF with `sel_i` = 4'b0010 leaves OUT = 0xA5.
- With IEN[3] = 1 and POL[3] = 1, raise `pin_input[3]`: IN[3] = 1 after 2 cycles (SYNC_STAGES = 2); PEND = 0x08 and `interrupt` = 1 after 3 cycles. Write PEND = 0x08: PEND = 0 and `interrupt` = 0.
- Issue a W1C of PEND[0] in the same cycle as a new falling edge on pin 0 (POL[0] = 0, IEN[0] = 1): PEND[0] stays 1.
- Set IEN[2] = 0 and toggle pin 2: PEND stays 0. Set PEND[5] via an edge, then clear IEN[5]: PEND[5] stays 1 and `interrupt` = 0.
- With `GPIO_IRQ_BOTH_EDGE_EN` defined, set BOTH[1] = 1 and IEN[1] = 1, then raise, clear, and lower pin 1: PEND[1] sets on both edges. Without the macro, writing 0x18 then reading it returns 0.

Source files
------------

// File: rtl/gpio_irq.sv
// gpio_irq: Wishbone GPIO slave with per-pin direction control, a
// SYNC_STAGES-deep input synchroniser and per-pin edge-triggered interrupts
// with sticky, write-1-to-clear pending bits.
// Optional feature: define GPIO_IRQ_BOTH_EDGE_EN to add the BOTH register at
// offset 0x18, which lets a pin interrupt on either edge. Without it, 0x18
// reads 0 and ignores writes.
module gpio_irq #(
    parameter logic [31:0] BASE_ADDRESS = 32'h4000_0000,
    parameter int          WIDTH        = 8,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stb_i,
    input  logic             cyc_i,
    input  logic [31:0]      adr_i,
    input  logic [3:0]       sel_i,
    input  logic [31:0]      dat_i,
    output logic [31:0]      dat_o,
    input  logic             we_i,
    output logic             ack_o,
    output logic             err_o,
    output logic             rty_o,
    input  logic [WIDTH-1:0] pin_input,
    output logic [WIDTH-1:0] pin_output,
    output logic [WIDTH-1:0] pin_oe,
    output logic             interrupt
);

    typedef enum logic [2:0] {
        REG_IN   = 3'd0,
        REG_OUT  = 3'd1,
        REG_DIR  = 3'd2,
        REG_IEN  = 3'd3,
        REG_POL  = 3'd4,
        REG_PEND = 3'd5,
        REG_BOTH = 3'd6,
        REG_RSVD = 3'd7
    } reg_idx_e;

    // Byte-lane merge of bus write data into a WIDTH-bit register.
    function automatic logic [WIDTH-1:0] f_merge(input logic [WIDTH-1:0] old_val,
                                                 input logic [WIDTH-1:0] new_val,
                                                 input logic [WIDTH-1:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_ien;
    logic [WIDTH-1:0] r_pol;
    logic [WIDTH-1:0] r_pend;
`ifdef GPIO_IRQ_BOTH_EDGE_EN
    logic [WIDTH-1:0] r_both;
`endif
    logic             r_ack;
    logic [31:0]      r_dat;

    logic             w_hit;
    logic             w_access;
    logic             w_wr;
    reg_idx_e         w_reg;
    logic [31:0]      w_lane_mask;
    logic [WIDTH-1:0] w_wmask;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_w1c;
    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [31:0]      w_rdata;
    logic             w_unused_bits;

    // A new transaction starts only when no ack is outstanding, so a held
    // strobe produces one ack every other cycle.
    assign w_hit       = stb_i & cyc_i & (adr_i[31:5] == BASE_ADDRESS[31:5]);
    assign w_access    = w_hit & ~r_ack;
    assign w_wr        = w_access & we_i;
    assign w_reg       = reg_idx_e'(adr_i[4:2]);
    assign w_lane_mask = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
    assign w_wmask     = w_lane_mask[WIDTH-1:0];
    assign w_wdata     = dat_i[WIDTH-1:0];
    assign w_w1c       = (w_wr && (w_reg == REG_PEND)) ? (w_wdata & w_wmask) : '0;

    // Address bits below the word and data/lane bits above WIDTH are not
    // decoded by this block.
    assign w_unused_bits = ^{adr_i[1:0], dat_i, w_lane_mask};

    assign w_in   = r_sync[SYNC_STAGES-1];
    assign w_rise = w_in & ~r_prev;
    assign w_fall = ~w_in & r_prev;

`ifdef GPIO_IRQ_BOTH_EDGE_EN
    assign w_edge = r_ien & ((r_both & (w_rise | w_fall))
                           | (~r_both & ((r_pol & w_rise) | (~r_pol & w_fall))));
`else
    assign w_edge = r_ien & ((r_pol & w_rise) | (~r_pol & w_fall));
`endif

    // Synchroniser chain for the asynchronous pins plus a one-cycle delayed
    // copy of its output for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the chain is cleared on reset so IN reads 0 and the edge
            // detector starts from a known level instead of stale pin history.
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_prev <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage take its
            // neighbour's pre-edge value; blocking ones would collapse the
            // chain into a single flop.
            r_sync[0] <= pin_input;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= w_in;
        end
    end

    // Read multiplexer; bits at and above WIDTH read as zero.
    always_comb begin
        // NOTE: default first so every path assigns w_rdata and no latch is
        // inferred for unlisted or reserved offsets.
        w_rdata = '0;
        case (w_reg)
            REG_IN:   w_rdata[WIDTH-1:0] = w_in;
            REG_OUT:  w_rdata[WIDTH-1:0] = r_out;
            REG_DIR:  w_rdata[WIDTH-1:0] = r_dir;
            REG_IEN:  w_rdata[WIDTH-1:0] = r_ien;
            REG_POL:  w_rdata[WIDTH-1:0] = r_pol;
            REG_PEND: w_rdata[WIDTH-1:0] = r_pend;
`ifdef GPIO_IRQ_BOTH_EDGE_EN
            REG_BOTH: w_rdata[WIDTH-1:0] = r_both;
`endif
            default:  ;
        endcase
    end

    // Control registers and pending bits; an edge set beats a same-cycle clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out  <= '0;
            r_dir  <= '0;
            r_ien  <= '0;
            r_pol  <= '0;
            r_pend <= '0;
`ifdef GPIO_IRQ_BOTH_EDGE_EN
            r_both <= '0;
`endif
        end else begin
            if (w_wr) begin
                case (w_reg)
                    REG_OUT:  r_out  <= f_merge(r_out, w_wdata, w_wmask);
                    REG_DIR:  r_dir  <= f_merge(r_dir, w_wdata, w_wmask);
                    REG_IEN:  r_ien  <= f_merge(r_ien, w_wdata, w_wmask);
                    REG_POL:  r_pol  <= f_merge(r_pol, w_wdata, w_wmask);
`ifdef GPIO_IRQ_BOTH_EDGE_EN
                    REG_BOTH: r_both <= f_merge(r_both, w_wdata, w_wmask);
`endif
                    default:  ;
                endcase
            end
            r_pend <= (r_pend & ~w_w1c) | w_edge;
        end
    end

    // Bus response: one-cycle ack, read data registered alongside it and
    // zero otherwise so it can be OR-combined on the shared bus.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_access;
            r_dat <= (w_access && !we_i) ? w_rdata : '0;
        end
    end

    assign ack_o      = r_ack;
    assign dat_o      = r_dat;
    assign err_o      = 1'b0;
    assign rty_o      = 1'b0;
    assign pin_output = r_out;
    assign pin_oe     = r_dir;
    assign interrupt  = |(r_pend & r_ien);

endmodule
